// File: rtl/mchan_cmd_splitter.sv
// Pops MCHAN transfer commands one at a time and splits them into bus fragments of at most
// MAX_BURST_BYTES. Define MCHAN_SPLIT_BOUNDARY_EN to also keep fragments inside 2^BOUNDARY_LOG2 regions.
module mchan_cmd_splitter #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned LEN_WIDTH       = 16,
  parameter int unsigned TID_WIDTH       = 4,
  parameter int unsigned MAX_BURST_BYTES = 256,
  parameter int unsigned BOUNDARY_LOG2   = 12,
  localparam int unsigned CMD_WIDTH      = 1 + TID_WIDTH + LEN_WIDTH + ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [CMD_WIDTH-1:0]  cmd_dat_i,
  input  logic                  cmd_gnt_i,
  output logic                  cmd_req_o,
  output logic                  frag_valid_o,
  input  logic                  frag_ready_i,
  output logic [ADDR_WIDTH-1:0] frag_addr_o,
  output logic [LEN_WIDTH-1:0]  frag_len_o,
  output logic [TID_WIDTH-1:0]  frag_tid_o,
  output logic                  frag_opc_o,
  output logic                  frag_last_o,
  output logic                  busy_o
);

  typedef enum logic {IDLE = 1'b0, SPLIT = 1'b1} state_e;

`ifdef MCHAN_SPLIT_BOUNDARY_EN
  localparam bit BoundaryEn = 1'b1;
`else
  localparam bit BoundaryEn = 1'b0;
`endif

  localparam logic [LEN_WIDTH-1:0]   MaxLen  = LEN_WIDTH'(MAX_BURST_BYTES);
  localparam logic [BOUNDARY_LOG2:0] BndSize = {1'b1, {BOUNDARY_LOG2{1'b0}}};

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_WIDTH-1:0]  rem_len_q, rem_len_d;
  logic [TID_WIDTH-1:0]  tid_q, tid_d;
  logic                  opc_q, opc_d;

  logic                  cmd_opc;
  logic [TID_WIDTH-1:0]  cmd_tid;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic [ADDR_WIDTH-1:0] cmd_addr;

  logic [BOUNDARY_LOG2:0] bnd_room;
  logic [LEN_WIDTH-1:0]   burst_len;
  logic [LEN_WIDTH-1:0]   frag_len;
  logic                   frag_last;
  logic                   cmd_pop;
  logic                   frag_hs;

  assign {cmd_opc, cmd_tid, cmd_len, cmd_addr} = cmd_dat_i;

  // Fragment size depends on registers only, so the downstream sees no input-to-output path.
  assign bnd_room  = BndSize - {1'b0, cur_addr_q[BOUNDARY_LOG2-1:0]};
  assign burst_len = (rem_len_q < MaxLen) ? rem_len_q : MaxLen;
  assign frag_len  = (BoundaryEn && (LEN_WIDTH'(bnd_room) < burst_len)) ? LEN_WIDTH'(bnd_room)
                                                                        : burst_len;
  assign frag_last = (state_q == SPLIT) && (rem_len_q == frag_len);

  assign cmd_pop = cmd_req_o & cmd_gnt_i;
  assign frag_hs = frag_valid_o & frag_ready_i;

  // NOTE: sequential state is written with non-blocking assignments only, so every register
  // samples the pre-edge value of every other register regardless of process ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      rem_len_q  <= '0;
      tid_q      <= '0;
      opc_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      rem_len_q  <= rem_len_d;
      tid_q      <= tid_d;
      opc_q      <= opc_d;
    end
  end

  always_comb begin
    // NOTE: every _d gets a default first; a path that left one unassigned would infer a latch.
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    rem_len_d  = rem_len_q;
    tid_d      = tid_q;
    opc_d      = opc_q;
    // A pop only happens in IDLE or on the last-fragment handshake, so it always wins here.
    if (cmd_pop) begin
      cur_addr_d = cmd_addr;
      rem_len_d  = cmd_len;
      tid_d      = cmd_tid;
      opc_d      = cmd_opc;
      state_d    = (cmd_len != '0) ? SPLIT : IDLE;
    end else if (frag_hs) begin
      if (frag_last) begin
        state_d = IDLE;
      end else begin
        cur_addr_d = cur_addr_q + ADDR_WIDTH'(frag_len);
        rem_len_d  = rem_len_q - frag_len;
      end
    end
  end

  always_comb begin
    cmd_req_o    = 1'b0;
    frag_valid_o = 1'b0;
    busy_o       = 1'b0;
    unique case (state_q)
      // Masked by reset so no FIFO entry is consumed while the block is held in reset.
      IDLE:  cmd_req_o = cmd_gnt_i & rst_ni;
      SPLIT: begin
        frag_valid_o = 1'b1;
        busy_o       = 1'b1;
        cmd_req_o    = frag_ready_i & frag_last & cmd_gnt_i;
      end
    endcase
  end

  assign frag_addr_o = cur_addr_q;
  assign frag_len_o  = frag_len;
  assign frag_tid_o  = tid_q;
  assign frag_opc_o  = opc_q;
  assign frag_last_o = frag_last;

endmodule
